// File: rtl/ripple_count_monitor_pkg.sv
// Shared FSM encodings, transition classes and tally helpers for ripple_count_monitor.
// The RIPPLE_MON_MISS_CNT_EN build uses MISS_W and sat_add_miss for the skipped-count tally.
package ripple_count_monitor_pkg;

  localparam logic [1:0] S_INIT  = 2'd0;
  localparam logic [1:0] S_TRACK = 2'd1;
  localparam logic [1:0] S_ERR   = 2'd2;

  localparam int MISS_W = 8;

  typedef enum logic [2:0] {
    T_NONE,
    T_STEP,
    T_RESTART,
    T_SKIP,
    T_BACK
  } trans_t;

  function automatic logic [MISS_W-1:0] sat_add_miss(input logic [MISS_W-1:0] a,
                                                    input logic [MISS_W-1:0] b);
    logic [MISS_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[MISS_W] ? {MISS_W{1'b1}} : sum[MISS_W-1:0];
  endfunction

endpackage

// File: rtl/ripple_count_monitor_if.sv
// Bus between the ripple counter domain / system logic and ripple_count_monitor.
// miss_cnt exists only when RIPPLE_MON_MISS_CNT_EN is defined.
interface ripple_count_monitor_if #(
  parameter int CNT_W  = 4,
  parameter int WRAP_W = 8
);
  import ripple_count_monitor_pkg::*;

  logic [CNT_W-1:0]  cnt_in;
  logic              err_clr;
  logic              cnt_valid;
  logic [CNT_W-1:0]  cnt_out;
  logic              step;
  logic              wrap;
  logic              restart;
  logic [WRAP_W-1:0] wrap_cnt;
  logic              seq_err;
  logic [1:0]        state;
`ifdef RIPPLE_MON_MISS_CNT_EN
  logic [MISS_W-1:0] miss_cnt;
`endif

  modport master (
    output cnt_in, err_clr,
    input  cnt_valid, cnt_out, step, wrap, restart, wrap_cnt, seq_err, state
`ifdef RIPPLE_MON_MISS_CNT_EN
    , input miss_cnt
`endif
  );

  modport slave (
    input  cnt_in, err_clr,
    output cnt_valid, cnt_out, step, wrap, restart, wrap_cnt, seq_err, state
`ifdef RIPPLE_MON_MISS_CNT_EN
    , output miss_cnt
`endif
  );

endinterface

// File: rtl/ripple_count_monitor_sync_stable_filter.sv
// Two-flop synchroniser plus stability filter for a multi-bit ripple count.
// Bits of a ripple count resolve at different times, so only a value held STABLE_N edges is trusted.
module sync_stable_filter #(
  parameter int CNT_W    = 4,
  parameter int STABLE_N = 2
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic [CNT_W-1:0] i_cnt,
  input  logic             i_rearm,
  output logic             o_settled,
  output logic [CNT_W-1:0] o_value
);

  localparam int LEFT_W = (STABLE_N > 1) ? $clog2(STABLE_N) : 1;
  localparam logic [LEFT_W-1:0] LEFT_LOAD = LEFT_W'(STABLE_N - 1);

  logic [CNT_W-1:0]  r_s1;
  logic [CNT_W-1:0]  r_s2;
  logic [LEFT_W-1:0] r_left;
  logic              r_armed;
  logic              w_moving;

  // s2 is about to take a new value at the coming edge
  assign w_moving = (r_s1 != r_s2);

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_left  <= LEFT_LOAD;
      r_armed <= 1'b1;
    end else begin
      r_s1 <= i_cnt;
      r_s2 <= r_s1;
      if (w_moving || i_rearm) begin
        r_left  <= LEFT_LOAD;
        r_armed <= 1'b1;
      end else if (r_armed) begin
        if (r_left == '0) begin
          r_armed <= 1'b0;
        end else begin
          r_left <= r_left - LEFT_W'(1);
        end
      end
    end
  end

  // One pulse per settle event: armed drops on the edge that consumes it
  assign o_settled = r_armed && !w_moving && (r_left == '0);
  assign o_value   = r_s2;

endmodule

// File: rtl/ripple_count_monitor.sv
// Settled-count tracker for an asynchronous ripple up-counter: step/wrap/restart pulses, wrap tally,
// sticky sequence error. Optional skipped-count tally under RIPPLE_MON_MISS_CNT_EN.
module ripple_count_monitor
  import ripple_count_monitor_pkg::*;
#(
  parameter int CNT_W    = 4,
  parameter int STABLE_N = 2,
  parameter int WRAP_W   = 8
) (
  input  logic                   i_clk,
  input  logic                   i_clr,
  ripple_count_monitor_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              w_settled;
  logic [CNT_W-1:0]  w_value;
  logic [CNT_W-1:0]  w_next;
  logic              w_rearm;
  trans_t            w_trans;

  logic [1:0]        r_state;
  logic              r_cnt_valid;
  logic [CNT_W-1:0]  r_cnt_out;
  logic              r_step;
  logic              r_wrap;
  logic              r_restart;
  logic [WRAP_W-1:0] r_wrap_cnt;
  logic              r_seq_err;
`ifdef RIPPLE_MON_MISS_CNT_EN
  logic [MISS_W-1:0] r_miss_cnt;
  logic [CNT_W-1:0]  w_gap;
  assign w_gap = w_value - r_cnt_out - CNT_W'(1);
`endif

  // Leaving S_ERR (or an illegal state) must re-acquire even if the count never moves again
  assign w_rearm = ((r_state == S_ERR) && bus.err_clr) ||
                   ((r_state != S_INIT) && (r_state != S_TRACK) && (r_state != S_ERR));

  sync_stable_filter #(
    .CNT_W    (CNT_W),
    .STABLE_N (STABLE_N)
  ) u_filter (
    .i_clk     (i_clk),
    .i_clr     (i_clr),
    .i_cnt     (bus.cnt_in),
    .i_rearm   (w_rearm),
    .o_settled (w_settled),
    .o_value   (w_value)
  );

  assign w_next = r_cnt_out + CNT_W'(1);

  always_comb begin
    w_trans = T_NONE;
    if (w_settled && (w_value != r_cnt_out)) begin
      if (w_value == w_next) begin
        w_trans = T_STEP;
      end else if (w_value == '0) begin
        w_trans = T_RESTART;
      end else if (w_value > r_cnt_out) begin
        w_trans = T_SKIP;
      end else begin
        w_trans = T_BACK;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_state     <= S_INIT;
      r_cnt_valid <= 1'b0;
      r_cnt_out   <= '0;
      r_step      <= 1'b0;
      r_wrap      <= 1'b0;
      r_restart   <= 1'b0;
      r_wrap_cnt  <= '0;
      r_seq_err   <= 1'b0;
`ifdef RIPPLE_MON_MISS_CNT_EN
      r_miss_cnt  <= '0;
`endif
    end else begin
      r_step    <= 1'b0;
      r_wrap    <= 1'b0;
      r_restart <= 1'b0;
      case (r_state)
        S_INIT: begin
          if (w_settled) begin
            r_cnt_out   <= w_value;
            r_cnt_valid <= 1'b1;
            r_state     <= S_TRACK;
          end
        end
        S_TRACK: begin
          case (w_trans)
            T_STEP: begin
              r_cnt_out <= w_value;
              r_step    <= 1'b1;
              if (r_cnt_out == CNT_MAX) begin
                r_wrap <= 1'b1;
                if (r_wrap_cnt != {WRAP_W{1'b1}}) begin
                  r_wrap_cnt <= r_wrap_cnt + WRAP_W'(1);
                end
              end
            end
            T_RESTART: begin
              r_cnt_out <= '0;
              r_restart <= 1'b1;
            end
            T_SKIP, T_BACK: begin
              r_cnt_out <= w_value;
              r_seq_err <= 1'b1;
              r_state   <= S_ERR;
`ifdef RIPPLE_MON_MISS_CNT_EN
              if (w_trans == T_SKIP) begin
                r_miss_cnt <= sat_add_miss(r_miss_cnt, MISS_W'(w_gap));
              end
`endif
            end
            default: ;
          endcase
        end
        S_ERR: begin
          if (bus.err_clr) begin
            r_state     <= S_INIT;
            r_cnt_valid <= 1'b0;
            r_seq_err   <= 1'b0;
`ifdef RIPPLE_MON_MISS_CNT_EN
            r_miss_cnt  <= '0;
`endif
          end else if (w_settled) begin
            r_cnt_out <= w_value;
          end
        end
        default: begin
          r_state     <= S_INIT;
          r_cnt_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cnt_valid = r_cnt_valid;
  assign bus.cnt_out   = r_cnt_out;
  assign bus.step      = r_step;
  assign bus.wrap      = r_wrap;
  assign bus.restart   = r_restart;
  assign bus.wrap_cnt  = r_wrap_cnt;
  assign bus.seq_err   = r_seq_err;
  assign bus.state     = r_state;
`ifdef RIPPLE_MON_MISS_CNT_EN
  assign bus.miss_cnt  = r_miss_cnt;
`endif

endmodule
